// File: rtl/i2c_pkg.sv
// Shared types and defaults for the I2C slave register bank.
package i2c_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GET_PTR = 2'd1,
        WR_DATA = 2'd2,
        RD_DATA = 2'd3
    } state_e;

    localparam int         DEF_REG_NUM = 16;
    localparam logic [7:0] DEF_RST_VAL = 8'h00;

endpackage

// File: rtl/i2c_regbank_mem.sv
// Register array with an RO-gated I2C write port, a host write port and two async read ports.
module i2c_regbank_mem
    import i2c_pkg::*;
#(
    parameter int                 REG_NUM = DEF_REG_NUM,
    parameter int                 PTR_W   = $clog2(REG_NUM),
    parameter logic [REG_NUM-1:0] RO_MASK = {REG_NUM{1'b0}},
    parameter logic [7:0]         RST_VAL = DEF_RST_VAL
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i2c_we,
    input  logic [PTR_W-1:0] i2c_addr,
    input  logic [7:0]       i2c_wdata,
    output logic             i2c_wr_ok,
    input  logic             host_we,
    input  logic [PTR_W-1:0] host_addr,
    input  logic [7:0]       host_wdata,
    output logic             host_conflict,
    input  logic [PTR_W-1:0] rd_addr_a,
    output logic [7:0]       rd_data_a,
    input  logic [PTR_W-1:0] rd_addr_b,
    output logic [7:0]       rd_data_b
);

    logic [REG_NUM-1:0][7:0] mem_q, mem_d;

    // The I2C write is applied last so it overrides a host write to the same register.
    always_comb begin
        i2c_wr_ok     = i2c_we && !RO_MASK[i2c_addr];
        host_conflict = host_we && i2c_wr_ok && (host_addr == i2c_addr);
        mem_d         = mem_q;
        if (host_we)
            mem_d[host_addr] = host_wdata;
        if (i2c_wr_ok)
            mem_d[i2c_addr] = i2c_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mem_q <= {REG_NUM{RST_VAL}};
        else
            mem_q <= mem_d;
    end

    assign rd_data_a = mem_q[rd_addr_a];
    assign rd_data_b = mem_q[rd_addr_b];

endmodule

// File: rtl/i2c_slave_regbank.sv
// Byte-handshake back end for an I2C slave: pointer/data protocol FSM over a local register bank.
module i2c_slave_regbank
    import i2c_pkg::*;
#(
    parameter int                 REG_NUM = DEF_REG_NUM,
    parameter logic [REG_NUM-1:0] RO_MASK = {REG_NUM{1'b0}},
    parameter logic [7:0]         RST_VAL = DEF_RST_VAL,
    localparam int                PTR_W   = $clog2(REG_NUM)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rd_reg_full,
    input  logic [7:0]       byte_rd_o,
    output logic             rd_clr,
    input  logic             wr_reg_empty,
    output logic [7:0]       byte_wr_i,
    output logic             wr_rdy,
    input  logic             addr_match,
    input  logic             trans_dir,
    input  logic             get_nack,
    input  logic             trans_stop,
    input  logic             bus_err,
    input  logic             host_we,
    input  logic [PTR_W-1:0] host_addr,
    input  logic [7:0]       host_wdata,
    output logic [7:0]       host_rdata,
    output logic             host_conflict,
    output logic             i2c_wr_stb,
    output logic [PTR_W-1:0] i2c_wr_addr,
    output logic [PTR_W-1:0] reg_ptr,
    output logic             busy,
    output logic             err_sticky,
    input  logic             err_clr
);

    state_e           state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             addr_match_q;
    logic             dir_q, dir_d;
    logic             rd_clr_q, rd_clr_d;
    logic             wr_rdy_q, wr_rdy_d;
    logic [7:0]       byte_wr_q, byte_wr_d;
    logic             stb_q, stb_d;
    logic [PTR_W-1:0] stb_addr_q, stb_addr_d;
    logic             conflict_q;
    logic             err_q, err_d;

    logic             addr_evt;
    logic             i2c_we;
    logic             i2c_wr_ok;
    logic             mem_conflict;
    logic [7:0]       ptr_rdata;

    // New transaction on a fresh match, or a repeated start that flips the direction.
    assign addr_evt = addr_match && (!addr_match_q || (trans_dir != dir_q));

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        dir_d      = dir_q;
        // Every received byte is consumed, whatever the state, so the slave never stalls.
        rd_clr_d   = rd_reg_full && !rd_clr_q;
        wr_rdy_d   = 1'b0;
        byte_wr_d  = byte_wr_q;
        i2c_we     = 1'b0;
        err_d      = bus_err ? 1'b1 : (err_clr ? 1'b0 : err_q);

        if (addr_evt)
            dir_d = trans_dir;

        if (trans_stop || bus_err) begin
            state_d = IDLE;
        end else if (addr_evt) begin
            state_d = trans_dir ? RD_DATA : GET_PTR;
        end else begin
            case (state_q)
                GET_PTR: begin
                    if (rd_clr_d) begin
                        ptr_d   = byte_rd_o[PTR_W-1:0];
                        state_d = WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (rd_clr_d) begin
                        i2c_we = 1'b1;
                        ptr_d  = ptr_q + PTR_W'(1);
                    end
                end
                RD_DATA: begin
                    // A byte still sitting in the transmit register was never sent: rewind.
                    if (get_nack) begin
                        if (!wr_reg_empty)
                            ptr_d = ptr_q - PTR_W'(1);
                        state_d = IDLE;
                    end else if (wr_reg_empty && !wr_rdy_q) begin
                        byte_wr_d = ptr_rdata;
                        wr_rdy_d  = 1'b1;
                        ptr_d     = ptr_q + PTR_W'(1);
                    end
                end
                default: ;
            endcase
        end

        stb_d      = i2c_wr_ok;
        stb_addr_d = i2c_wr_ok ? ptr_q : stb_addr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            addr_match_q <= 1'b0;
            dir_q        <= 1'b0;
            rd_clr_q     <= 1'b0;
            wr_rdy_q     <= 1'b0;
            byte_wr_q    <= 8'h00;
            stb_q        <= 1'b0;
            stb_addr_q   <= '0;
            conflict_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            addr_match_q <= addr_match;
            dir_q        <= dir_d;
            rd_clr_q     <= rd_clr_d;
            wr_rdy_q     <= wr_rdy_d;
            byte_wr_q    <= byte_wr_d;
            stb_q        <= stb_d;
            stb_addr_q   <= stb_addr_d;
            conflict_q   <= mem_conflict;
            err_q        <= err_d;
        end
    end

    i2c_regbank_mem #(
        .REG_NUM (REG_NUM),
        .PTR_W   (PTR_W),
        .RO_MASK (RO_MASK),
        .RST_VAL (RST_VAL)
    ) u_mem (
        .clk           (clk),
        .rst_n         (rst_n),
        .i2c_we        (i2c_we),
        .i2c_addr      (ptr_q),
        .i2c_wdata     (byte_rd_o),
        .i2c_wr_ok     (i2c_wr_ok),
        .host_we       (host_we),
        .host_addr     (host_addr),
        .host_wdata    (host_wdata),
        .host_conflict (mem_conflict),
        .rd_addr_a     (host_addr),
        .rd_data_a     (host_rdata),
        .rd_addr_b     (ptr_q),
        .rd_data_b     (ptr_rdata)
    );

    assign rd_clr        = rd_clr_q;
    assign wr_rdy        = wr_rdy_q;
    assign byte_wr_i     = byte_wr_q;
    assign i2c_wr_stb    = stb_q;
    assign i2c_wr_addr   = stb_addr_q;
    assign host_conflict = conflict_q;
    assign reg_ptr       = ptr_q;
    assign busy          = (state_q != IDLE);
    assign err_sticky    = err_q;

endmodule

// File: doc/i2c_slave_regbank.md
Name: i2c_slave_regbank

Overview:
- Register-bank back end that sits directly downstream of I2C_slave and consumes its byte-level handshake.
- Converts I2C transactions into reads and writes of a local register array.
  - The first byte written after the address phase sets the register pointer.
  - Further written bytes store at the pointer.
  - Read transactions return data from the pointer.
  - The pointer auto-increments after each access.
- A host-side port gives system logic direct access to the same array.

Parameters:
- REG_NUM, 16: number of 8-bit registers. Must be a power of two, 2..256.
- PTR_W, $clog2(REG_NUM): pointer width (derived, not overridden).
- RO_MASK, {REG_NUM{1'b0}}: bit i = 1 makes register i read-only from I2C.
- RST_VAL, 8'h00: reset value of every register.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rd_reg_full  in  1  slave holds a received byte
- byte_rd_o  in  8  received byte from slave
- rd_clr  out  1  one-cycle pulse: byte consumed
- wr_reg_empty  in  1  slave transmit register empty
- byte_wr_i  out  8  byte to transmit
- wr_rdy  out  1  one-cycle pulse: byte_wr_i valid
- addr_match, trans_dir, get_nack, trans_stop, bus_err  in  1 each  slave status (trans_dir 1 = master read)
- host_we  in  1  host write enable
- host_addr  in  PTR_W  host register address
- host_wdata  in  8  host write data
- host_rdata  out  8  combinational read of reg[host_addr]
- host_conflict  out  1  pulse: host write dropped
- i2c_wr_stb  out  1  pulse: I2C wrote a register
- i2c_wr_addr  out  PTR_W  address of that write
- reg_ptr  out  PTR_W  current pointer
- busy  out  1  state != IDLE
- err_sticky  out  1  set by bus_err
- err_clr  in  1  clears err_sticky

Behaviour:
- Reset (async, rst_n low): all outputs 0 except byte_wr_i = 8'h00; registers = RST_VAL; ptr = 0; state = IDLE.
- Reset mid-transaction discards the transaction immediately.
- Address-phase event: rising edge of addr_match, or addr_match high while trans_dir differs from the latched direction (repeated start). Evaluated in every state. trans_dir is latched on the event.
- FSM states: IDLE, GET_PTR, WR_DATA, RD_DATA.
  - Address event with trans_dir = 0 -> GET_PTR.
  - Address event with trans_dir = 1 -> RD_DATA. Pointer is kept, which supports the write-pointer / restart / read sequence.
  - GET_PTR, rd_reg_full: pulse rd_clr; ptr <= byte_rd_o[PTR_W-1:0] (upper bits ignored); go to WR_DATA.
  - WR_DATA, rd_reg_full: pulse rd_clr.
    - If RO_MASK[ptr] = 0: write reg[ptr] and pulse i2c_wr_stb with i2c_wr_addr = ptr.
    - If RO_MASK[ptr] = 1: the byte is discarded silently.
    - In both cases ptr <= ptr+1, wrapping REG_NUM-1 -> 0.
  - RD_DATA, wr_reg_empty and no load in the previous cycle: byte_wr_i <= reg[ptr], pulse wr_rdy, ptr <= ptr+1 (wraps).
  - RD_DATA, get_nack: if ~wr_reg_empty (a prefetched byte was never sent), ptr <= ptr-1. Go to IDLE.
  - Any state, trans_stop or bus_err -> IDLE. bus_err also sets err_sticky.
- rd_clr and wr_rdy are registered, at most one cycle high. They are never asserted in back-to-back cycles for the same byte.
- Latency: rd_reg_full high at edge N gives rd_clr high in cycle N+1 and the register updated at N+1. wr_reg_empty at N gives wr_rdy in N+1.
- Write collision: host_we and an I2C write to the same address in the same cycle. The I2C write wins and host_conflict pulses. Host writes to other addresses always take effect.
- host_rdata reflects a write on the following cycle.
- err_clr and bus_err in the same cycle: set wins.
- Received bytes outside GET_PTR/WR_DATA (e.g. in IDLE) are still cleared with rd_clr and then discarded, so the slave never stalls.

Decomposition:
- Package i2c_pkg: state enum (IDLE, GET_PTR, WR_DATA, RD_DATA) and default REG_NUM/RST_VAL constants.
- One sub-module, i2c_regbank_mem:
  - REG_NUM x 8 flops with RO_MASK-gated I2C write port, host write port and collision arbitration.
  - Two asynchronous read ports.
- The FSM and pointer stay in the top level.

Test Plan:
- Write 0x25 addr, bytes 0x03, 0xA5, 0x5A -> reg[3] = 0xA5, reg[4] = 0x5A, ptr = 5, two i2c_wr_stb pulses, rd_clr count 3.
- Write ptr 0x0F, bytes 0x11, 0x22 with REG_NUM = 16 -> reg[15] = 0x11, reg[0] = 0x22 (wrap), ptr = 1.
- Write ptr 0x02, restart, read 3 bytes with NACK on the last -> master receives reg[2..4]; ptr ends at 5 (prefetch rewound if loaded).
- RO_MASK = 16'h0001, write ptr 0, byte 0xFF -> reg[0] stays 0x00, no i2c_wr_stb, ptr = 1.
- host_we to addr 3 with data 0x77 in the same cycle as an I2C write of 0x99 to addr 3 -> reg[3] = 0x99, host_conflict one pulse.
- Inject bus_err mid-write, then assert rst_n low mid-read -> err_sticky = 1 and state IDLE; after reset all registers 0x00, outputs 0, err_sticky = 0.
